uart_rx_byte: RTL and testbench

//   UART receiver that deserialises the 8N1 serial line into bytes for the perceptron core.
//   It sits between the rx pin and the core's command/weight loader.
//   It samples each bit at mid-period, checks the stop bit, and presents each byte on a valid/ready hold register.

---
 rtl/uart_rx_byte.sv | 173 +++++++++++++++++
 tb/tb_uart_rx_byte.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver feeding bytes to the perceptron core's command/weight loader.
// Latency: valid rises about 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 clk after the rx falling edge.
// Backpressure: one-entry valid/ready hold register; a byte completed while it is full is dropped with an overrun pulse.
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active-high
//   rx           serial line, idle high, asynchronous to clk
//   data         received byte, stable while valid=1
//   valid        data holds an unconsumed byte
//   ready        consumer accepts data when valid && ready
//   busy         frame reception in progress (state != IDLE), registered
//   framing_err  1-cycle pulse: stop bit sampled low, byte discarded
//   overrun      1-cycle pulse: byte completed while hold register full, byte dropped
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       framing_err,
  output logic       overrun
);

  // Last count of half a bit period (start-bit centre) and of a full bit period.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  // Two-flop synchroniser; both flops reset to the idle-line level so a
  // reset release never fabricates a falling edge.
  logic rx_meta;
  logic rx_s;

  logic cnt_bit_done;
  logic deliver;
  logic accept;

  always_comb begin
    cnt_bit_done = (cnt == BIT_LAST);
    // Good stop bit: byte goes to the hold register on this edge.
    deliver      = (state == STOP) && cnt_bit_done && rx_s;
    accept       = valid && ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      data        <= '0;
      valid       <= 1'b0;
      busy        <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      rx_meta     <= rx;
      rx_s        <= rx_meta;
      framing_err <= 1'b0;
      overrun     <= 1'b0;

      // Hold register. A consumer taking the old byte in the delivery cycle
      // frees the slot, so the new byte replaces it without an overrun.
      if (deliver) begin
        if (!valid || ready) begin
          data  <= shreg;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (accept) begin
        valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!rx_s) begin
              // Still low at the centre of the start bit: real frame.
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              // Short low pulse: treat as noise, no flag.
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt_bit_done) begin
            cnt   <= '0;
            // LSB arrives first, so shifting in at the MSB leaves bit 0 at
            // shreg[0] after eight samples.
            shreg <= {rx_s, shreg[7:1]};
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          if (cnt_bit_done) begin
            cnt <= '0;
            if (rx_s) begin
              // Returning to IDLE right away lets a back-to-back start bit
              // be seen on the very next cycle.
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              framing_err <= 1'b1;
              state       <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        BREAK: begin
          // A held-low line must not be read as a stream of frames; wait for
          // it to return to idle before hunting for the next start bit.
          cnt <= '0;
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Testbench for uart_rx_byte: scoreboard of expected bytes, popped by a monitor
// on every accepted handshake; error pulses are tallied by the same monitor.
module tb_uart_rx_byte;

  localparam int CPB = 32;  // clk per bit for the DUT instance
  localparam int CW  = 6;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       busy;
  logic       framing_err;
  logic       overrun;

  uart_rx_byte #(
    .CLKS_PER_BIT(CPB),
    .CNT_W       (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .busy       (busy),
    .framing_err(framing_err),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  bit         busy_seen = 1'b0;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: samples on the falling edge, inputs change just after the rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (framing_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (busy) busy_seen = 1'b1;
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_byte: got 0x%0h, expected no byte", data);
        end else begin
          check("rx_byte", int'(data), int'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One 8N1 frame, LSB first, cpb clocks per bit; line left at the stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int cpb);
    rx = 1'b0;
    tick(cpb);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(cpb);
    end
    rx = stop_bit;
    tick(cpb);
  endtask

  int fe0;
  int ov0;

  initial begin
    rst   = 1'b1;
    rx    = 1'b1;
    ready = 1'b0;
    tick(5);
    check("reset_data", int'(data), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_framing_err", int'(framing_err), 0);
    check("reset_overrun", int'(overrun), 0);
    rst = 1'b0;
    tick(200);
    check("idle_no_valid", int'(valid), 0);
    check("idle_no_busy", int'(busy), 0);

    // Byte sweep at nominal rate.
    ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back(8'(k * 17));
      send_frame(8'(k * 17), 1'b1, CPB);
      tick(20);
    end
    // Rate tolerance: one clock slow and fast per bit.
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, CPB - 1);
    tick(20);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, CPB + 1);
    tick(20);
    // Back-to-back frames with a single stop bit.
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h80);
    send_frame(8'h01, 1'b1, CPB);
    send_frame(8'h80, 1'b1, CPB);
    tick(20);
    check("sweep_queue_drained", exp_q.size(), 0);
    check("sweep_framing_pulses", fe_cnt, 0);
    check("sweep_overrun_pulses", ov_cnt, 0);

    // Glitch shorter than half a bit.
    busy_seen = 1'b0;
    rx = 1'b0;
    tick(8);
    rx = 1'b1;
    tick(60);
    check("glitch_busy_seen", int'(busy_seen), 1);
    check("glitch_busy_end", int'(busy), 0);
    check("glitch_no_valid", int'(valid), 0);
    check("glitch_no_framing", fe_cnt, 0);

    // Framing error, held-low line, then recovery.
    fe0 = fe_cnt;
    send_frame(8'hA3, 1'b0, CPB);
    tick(200);
    check("break_no_valid", int'(valid), 0);
    rx = 1'b1;
    tick(20);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, CPB);
    tick(20);
    check("framing_pulse_count", fe_cnt - fe0, 1);
    check("framing_queue_drained", exp_q.size(), 0);

    // Overrun with the consumer stalled.
    ready = 1'b0;
    ov0 = ov_cnt;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, CPB);
    tick(20);
    send_frame(8'h22, 1'b1, CPB);
    tick(20);
    check("overrun_data_held", int'(data), 8'h11);
    check("overrun_valid_held", int'(valid), 1);
    check("overrun_pulse_count", ov_cnt - ov0, 1);
    ready = 1'b1;
    tick(2);
    ready = 1'b0;
    check("overrun_consumed_valid", int'(valid), 0);
    check("overrun_queue_drained", exp_q.size(), 0);

    // Consumer takes the old byte in the delivery cycle of the new one.
    // Stop sample lands 307 edges after the start edge; ready covers 306..308.
    ov0 = ov_cnt;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_frame(8'h11, 1'b1, CPB);
    tick(20);
    fork
      send_frame(8'h22, 1'b1, CPB);
      begin
        tick(305);
        ready = 1'b1;
        tick(3);
        ready = 1'b0;
      end
    join
    tick(20);
    check("handoff_no_overrun", ov_cnt - ov0, 0);
    ready = 1'b1;
    tick(5);
    check("handoff_queue_drained", exp_q.size(), 0);

    // Reset during data bit 4 of 0x99, released while the line is high (bit 7).
    fork
      send_frame(8'h99, 1'b1, CPB);
      begin
        tick(5 * CPB + CPB / 2);
        rst = 1'b1;
        tick(2);
        check("midreset_busy", int'(busy), 0);
        check("midreset_valid", int'(valid), 0);
        tick(3 * CPB - 2);
        rst = 1'b0;
      end
    join
    tick(20);
    check("midreset_idle", int'(busy), 0);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, CPB);
    tick(20);
    check("midreset_queue_drained", exp_q.size(), 0);
    check("final_framing_pulses", fe_cnt - fe0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
